banner_overlay: RTL

Parametrised successor to the fixed game-over banner, sitting between the VGA pixel scanner and the final colour mux. It fetches a rectangular ROM image at a runtime-animated vertical position, slides it down on trigger, optionally blinks it once settled, applies a colour-key transparency, and delivers a pipelined `en`/`rgb` pair aligned to a fixed latency.

---
 rtl/banner_overlay.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/banner_overlay.sv
// Sliding, optionally blinking ROM banner with colour-key transparency.
// Pixel path: x/y -> registered ROM address -> ROM -> registered en/rgb (latency MEM_LATENCY+2).
module banner_overlay #(
  parameter int          IMG_W        = 640,
  parameter int          IMG_H        = 160,
  parameter int          X0           = 0,
  parameter int          START_Y      = 0,
  parameter int          TARGET_Y     = 160,
  parameter int          SLIDE_STEP   = 8,
  parameter int          BLINK_PERIOD = 0,
  parameter logic [11:0] KEY_COLOR    = 12'hF00,
  parameter int          MEM_LATENCY  = 1,
  parameter int          ADDR_W       = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trigger,
  input  logic              clear,
  input  logic              frame_start,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [11:0]       mem_data,
  output logic              en,
  output logic [11:0]       rgb,
  output logic              settled
);

  typedef enum logic [1:0] {S_IDLE, S_SLIDE, S_HOLD} state_t;

  localparam logic [15:0] BP_LAST = (BLINK_PERIOD > 0) ? 16'(BLINK_PERIOD - 1) : '0;

  state_t          state_q;
  logic [9:0]      cur_y_q;
  logic            vis_q;
  logic [15:0]     cnt_q;
  logic            settled_q;

  logic [10:0]     sum_c;
  logic [9:0]      next_y_c;

  assign sum_c    = {1'b0, cur_y_q} + 11'(SLIDE_STEP);
  assign next_y_c = (sum_c >= 11'(TARGET_Y)) ? 10'(TARGET_Y) : sum_c[9:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cur_y_q   <= 10'(START_Y);
      vis_q     <= 1'b1;
      cnt_q     <= '0;
      settled_q <= 1'b0;
    end else if (clear) begin
      state_q   <= S_IDLE;
      cur_y_q   <= 10'(START_Y);
      vis_q     <= 1'b1;
      cnt_q     <= '0;
      settled_q <= 1'b0;
    end else if (frame_start) begin
      case (state_q)
        S_IDLE: begin
          cur_y_q <= 10'(START_Y);
          if (trigger) state_q <= S_SLIDE;
        end
        S_SLIDE: begin
          cur_y_q <= next_y_c;
          if (next_y_c == 10'(TARGET_Y)) begin
            state_q   <= S_HOLD;
            vis_q     <= 1'b1;
            cnt_q     <= '0;
            settled_q <= 1'b1;
          end
        end
        S_HOLD: begin
          cur_y_q <= 10'(TARGET_Y);
          if (BLINK_PERIOD > 0) begin
            if (cnt_q == BP_LAST) begin
              cnt_q <= '0;
              vis_q <= ~vis_q;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Region bounds are formed at 11 bits so the right/bottom edges never wrap.
  logic [10:0]       x_end_c;
  logic [10:0]       y_end_c;
  logic              inside_c;
  logic [31:0]       row_c;
  logic [31:0]       col_c;
  logic [ADDR_W-1:0] mem_addr_d;

  assign x_end_c  = 11'(X0) + 11'(IMG_W);
  assign y_end_c  = {1'b0, cur_y_q} + 11'(IMG_H);
  assign inside_c = (state_q != S_IDLE) && vis_q &&
                    ({1'b0, x} >= 11'(X0)) && ({1'b0, x} < x_end_c) &&
                    (y >= cur_y_q) && ({1'b0, y} < y_end_c);
  assign row_c    = 32'(y - cur_y_q);
  assign col_c    = 32'(x - 10'(X0));

  always_comb begin
    mem_addr_d = '0;
    if (inside_c) mem_addr_d = ADDR_W'(row_c * 32'(IMG_W) + col_c);
  end

  logic [ADDR_W-1:0]    mem_addr_q;
  logic [MEM_LATENCY:0] in_q;
  logic                 en_d;
  logic                 en_q;
  logic [11:0]          rgb_d;
  logic [11:0]          rgb_q;

  assign en_d  = in_q[MEM_LATENCY] && (mem_data != KEY_COLOR);
  assign rgb_d = en_d ? mem_data : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr_q <= '0;
      in_q       <= '0;
      en_q       <= 1'b0;
      rgb_q      <= '0;
    end else begin
      mem_addr_q <= mem_addr_d;
      if (MEM_LATENCY > 0) in_q <= {in_q[MEM_LATENCY-1:0], inside_c};
      else                 in_q <= inside_c;
      en_q       <= en_d;
      rgb_q      <= rgb_d;
    end
  end

  assign mem_addr = mem_addr_q;
  assign en       = en_q;
  assign rgb      = rgb_q;
  assign settled  = settled_q;

endmodule
